// File: rtl/bat_size_ctrl_if.sv
// Bat size controller bus: per-frame event pulses in, bat-mux control out.
//   startOfFrame  one-clock pulse per video frame
//   shrink_hit    collision requesting the small bat
//   grow_hit      collision requesting the big bat
//   game_restart  return to the big bat immediately
//   select        bat-mux select (0 = big, 1 = small)
//   small_active  small period (including blink phase) in progress
//   frames_left   frames remaining in the small period
//   expired       one-clock pulse on natural timeout
interface bat_size_ctrl_if;
    logic       startOfFrame;
    logic       shrink_hit;
    logic       grow_hit;
    logic       game_restart;
    logic       select;
    logic       small_active;
    logic [9:0] frames_left;
    logic       expired;

    modport master (
        output startOfFrame, shrink_hit, grow_hit, game_restart,
        input  select, small_active, frames_left, expired
    );

    modport slave (
        input  startOfFrame, shrink_hit, grow_hit, game_restart,
        output select, small_active, frames_left, expired
    );
endinterface

// File: rtl/bat_size_ctrl.sv
// Bat size controller: a shrink event switches to the small bat for
// DURATION_FRAMES frames; the final WARN_FRAMES frames blink the bat with a
// half-period of BLINK_FRAMES frames before reverting to the big bat.
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    bat_size_ctrl_if slave (event pulses in, registered outputs)
module bat_size_ctrl #(
    parameter int unsigned DURATION_FRAMES = 300,
    parameter int unsigned WARN_FRAMES     = 60,
    parameter int unsigned BLINK_FRAMES    = 8
) (
    input  logic            clk,
    input  logic            reset,
    bat_size_ctrl_if.slave  bus
);
    localparam int unsigned FL_W = 10;
    localparam int unsigned BC_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_SMALL  = 2'd1,
        ST_WARN   = 2'd2
    } state_e;

    state_e            state, state_n;
    logic [FL_W-1:0]   fl_q, fl_n, fl_dec;
    logic [BC_W-1:0]   bc_q, bc_n, bc_inc;
    logic              phase_q, phase_n;
    logic              expired_q, expired_n;
    logic              select_q, select_n;
    logic              small_q, small_n;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_NORMAL;
            fl_q      <= '0;
            bc_q      <= '0;
            phase_q   <= 1'b0;
            expired_q <= 1'b0;
            select_q  <= 1'b0;
            small_q   <= 1'b0;
        end else begin
            state     <= state_n;
            fl_q      <= fl_n;
            bc_q      <= bc_n;
            phase_q   <= phase_n;
            expired_q <= expired_n;
            select_q  <= select_n;
            small_q   <= small_n;
        end
    end

    // Next-state: hits take priority over the frame decrement
    always_comb begin
        state_n   = state;
        fl_n      = fl_q;
        bc_n      = bc_q;
        phase_n   = phase_q;
        expired_n = 1'b0;
        fl_dec    = fl_q - FL_W'(1);
        bc_inc    = bc_q + BC_W'(1);

        if (bus.game_restart || bus.grow_hit) begin
            state_n = ST_NORMAL;
            fl_n    = '0;
            bc_n    = '0;
            phase_n = 1'b0;
        end else if (bus.shrink_hit) begin
            state_n = ST_SMALL;
            fl_n    = FL_W'(DURATION_FRAMES);
            bc_n    = '0;
            phase_n = 1'b0;
        end else begin
            case (state)
                ST_NORMAL: ;
                ST_SMALL: begin
                    if (bus.startOfFrame && fl_q != '0) begin
                        fl_n = fl_dec;
                        if (fl_dec == FL_W'(WARN_FRAMES)) begin
                            state_n = ST_WARN;
                            bc_n    = '0;
                            phase_n = 1'b0;
                        end
                    end
                end
                ST_WARN: begin
                    if (bus.startOfFrame && fl_q != '0) begin
                        fl_n = fl_dec;
                        if (fl_dec == '0) begin
                            state_n   = ST_NORMAL;
                            bc_n      = '0;
                            phase_n   = 1'b0;
                            expired_n = 1'b1;
                        end else if (bc_inc == BC_W'(BLINK_FRAMES)) begin
                            bc_n    = '0;
                            phase_n = ~phase_q;
                        end else begin
                            bc_n = bc_inc;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding recovers to the big bat
                    state_n = ST_NORMAL;
                    fl_n    = '0;
                    bc_n    = '0;
                    phase_n = 1'b0;
                end
            endcase
        end
    end

    // Output decode of the next state, registered so select never glitches
    always_comb begin
        select_n = 1'b0;
        small_n  = 1'b0;
        case (state_n)
            ST_SMALL: begin
                select_n = 1'b1;
                small_n  = 1'b1;
            end
            ST_WARN: begin
                select_n = phase_n;
                small_n  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.select       = select_q;
    assign bus.small_active = small_q;
    assign bus.frames_left  = fl_q;
    assign bus.expired      = expired_q;
endmodule

// File: doc/bat_size_ctrl.md
BAT_SIZE_CTRL -- requirements
Module: bat_size_ctrl

Interface
REQ-001 Parameter DURATION_FRAMES, default 300: frames the small bat stays active after a shrink event.
REQ-002 Parameter WARN_FRAMES, default 60: final frames of the small period during which the bat blinks; legal range 1..DURATION_FRAMES-1.
REQ-003 Parameter BLINK_FRAMES, default 8: frames per blink half-period; legal range >=1.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 startOfFrame  in  1  one-clock pulse, once per video frame.
REQ-008 shrink_hit  in  1  one-clock pulse: ball or bonus collision requesting the small bat.
REQ-009 grow_hit  in  1  one-clock pulse: collision requesting the big bat.
REQ-010 game_restart  in  1  one-clock pulse: return to the big bat immediately.
REQ-011 select  out  1  bat-mux select: 0 = big bat, 1 = small bat; registered.
REQ-012 small_active  out  1  1 while the SMALL or WARN state is active; registered.
REQ-013 frames_left  out  10  frames remaining in the small period; 0 in NORMAL; registered.
REQ-014 expired  out  1  one-clock pulse when the small period times out naturally.

Function
REQ-015 The FSM SHALL have three states: NORMAL, SMALL and WARN.
REQ-016 In NORMAL: select=0, small_active=0, frames_left=0.
REQ-017 In SMALL: select=1, small_active=1.
REQ-018 In WARN: small_active=1; select=blink_phase.
REQ-019 shrink_hit in any state SHALL load frames_left=DURATION_FRAMES and enter SMALL, with outputs updated on the next clock edge (1-clock latency).
REQ-020 grow_hit or game_restart in any state SHALL enter NORMAL on the next edge: frames_left=0, no expired pulse.
REQ-021 Same-cycle priority SHALL be: game_restart > grow_hit > shrink_hit > startOfFrame decrement.
REQ-022 A shrink_hit in SMALL or WARN SHALL restart the full period; any cycle holding a hit SHALL NOT decrement.
REQ-023 In SMALL or WARN, each startOfFrame with no hit SHALL decrement frames_left by 1; in NORMAL startOfFrame SHALL be ignored.
REQ-024 SMALL->WARN when a decrement yields frames_left==WARN_FRAMES; on entry blink_phase=0 and the blink counter=0.
REQ-025 In WARN, each startOfFrame SHALL advance a blink counter; when the counter reaches BLINK_FRAMES it SHALL wrap to 0 and blink_phase SHALL toggle.
REQ-026 WARN->NORMAL when a decrement yields frames_left==0; expired=1 for exactly that one clock.
REQ-027 frames_left SHALL never underflow or exceed DURATION_FRAMES; the counter is 10 bits and DURATION_FRAMES<=1023.
REQ-028 Illegal or unreachable state encodings SHALL return to NORMAL on the next edge.
REQ-029 select SHALL be glitch-free: it changes only on clock edges, from registers.

Reset
REQ-030 Asserting reset SHALL immediately force NORMAL, select=0, small_active=0, frames_left=0, expired=0, blink_phase=0, blink counter=0, independent of clk.
REQ-031 Reset asserted mid-SMALL or mid-WARN SHALL discard the remaining period; after release the block idles in NORMAL until a shrink_hit.
REQ-032 The first clock edge after reset release SHALL honour any input pulse present.

Verification (bench parameters DURATION_FRAMES=10, WARN_FRAMES=4, BLINK_FRAMES=2)
REQ-033 Full period: shrink_hit, then 10 startOfFrame pulses -> select=1 for frames 10..5; WARN entered when frames_left=4; select pattern 0,0,1,1 over the last four frames; expired pulses once as frames_left reaches 0; select=0 afterwards.
REQ-034 Retrigger: shrink_hit with frames_left=3 (in WARN) -> frames_left=10, state SMALL, select=1, blink reset.
REQ-035 Simultaneous events: shrink_hit, grow_hit and startOfFrame in the same cycle while in SMALL -> NORMAL, frames_left=0, no expired pulse.
REQ-036 Async reset: reset asserted between clock edges with frames_left=6 -> all outputs 0 before the next edge; later startOfFrame pulses leave frames_left=0.
REQ-037 Idle: 20 startOfFrame pulses in NORMAL -> select=0, frames_left=0, expired never asserted.
